// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution front-end padding stage.
package conv_pkg;

  // Region of the padded raster that the next output beat falls in.
  typedef enum logic [2:0] {
    TOP   = 3'd0,
    LEFT  = 3'd1,
    BODY  = 3'd2,
    RIGHT = 3'd3,
    BOT   = 3'd4
  } pad_state_t;

  // Default sample width and channel count of one pixel.
  localparam int PIX_W_DEF = 8;
  localparam int CH_DEF    = 3;

  // Widest border the stage supports.
  localparam int PAD_MAX   = 7;

  // Bit offset of channel c inside a packed pixel.
  function automatic int chan_lsb(input int c, input int pix_w);
    return c * pix_w;
  endfunction

endpackage

// File: rtl/pad_out_reg.sv
// One-entry valid/ready output register carrying a padded beat and its markers.
module pad_out_reg
  import conv_pkg::*;
#(
  parameter int DW = CH_DEF * PIX_W_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ld,
  input  logic [DW-1:0] i_data,
  input  logic          i_eol,
  input  logic          i_eof,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_free
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_eol;
  logic          r_eof;

  // The slot can take a new beat when empty or when its beat leaves this cycle.
  assign o_free = !r_valid || i_ready;

  // Load a new beat, or drop the current one once the consumer has taken it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (i_ld) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_eol   <= i_eol;
      r_eof   <= i_eof;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_eol   = r_eol;
  assign o_eof   = r_eof;

endmodule

// File: rtl/conv_pad_stream.sv
// Zero-padding stage: wraps an unpadded raster stream in PAD border rows/columns.
module conv_pad_stream
  import conv_pkg::*;
#(
  parameter int                CH      = CH_DEF,
  parameter int                PIX_W   = PIX_W_DEF,
  parameter int                IMG_W   = 416,
  parameter int                IMG_H   = 416,
  parameter int                PAD     = 1,
  parameter logic [PIX_W-1:0]  PAD_VAL = '0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  input  logic [CH*PIX_W-1:0] i_s_data,
  input  logic                i_s_eol,
  output logic                o_m_valid,
  input  logic                i_m_ready,
  output logic [CH*PIX_W-1:0] o_m_data,
  output logic                o_m_eol,
  output logic                o_m_eof,
  output logic                o_frame_done,
  output logic                o_err
);

  localparam int DW = CH * PIX_W;
  localparam int OW = IMG_W + 2 * PAD;
  localparam int OH = IMG_H + 2 * PAD;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam pad_state_t ST_RESET = (PAD > 0) ? TOP : BODY;

  // Region of the padded raster at (row, col); rows take priority over columns.
  function automatic pad_state_t classify(input int row, input int col);
    if (row < PAD)                 return TOP;
    else if (row >= PAD + IMG_H)   return BOT;
    else if (col < PAD)            return LEFT;
    else if (col >= PAD + IMG_W)   return RIGHT;
    else                           return BODY;
  endfunction

  logic [CW-1:0] r_col, w_col_next;
  logic [RW-1:0] r_row, w_row_next;
  pad_state_t    r_state, w_state_next;
  logic          r_frame_done;
  logic          r_err;

  logic          w_free;
  logic          w_border;
  logic          w_ld;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_img_col_last;
  logic [DW-1:0] w_pad_pix;
  logic [DW-1:0] w_ld_data;

  // Border pixel: every channel carries PAD_VAL.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_pad_pix
      assign w_pad_pix[chan_lsb(gi, PIX_W) +: PIX_W] = PAD_VAL;
    end
  endgenerate

  assign w_col_last     = (int'(r_col) == OW - 1);
  assign w_row_last     = (int'(r_row) == OH - 1);
  assign w_img_col_last = (int'(r_col) == PAD + IMG_W - 1);

  // State register: position counters and region follow each output load.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_state <= ST_RESET;
    end else begin
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_state <= w_state_next;
    end
  end

  // Next-state: step the raster position on a load and reclassify it; wrap after the last beat.
  always_comb begin
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_state_next = r_state;
    if (w_ld) begin
      if (w_col_last) begin
        w_col_next = '0;
        w_row_next = w_row_last ? '0 : r_row + 1'b1;
      end else begin
        w_col_next = r_col + 1'b1;
      end
      w_state_next = classify(int'(w_row_next), int'(w_col_next));
    end
  end

  // Outputs of the FSM: input only requested in the image region, border beats self-generated.
  always_comb begin
    w_border  = (r_state != BODY);
    o_s_ready = (r_state == BODY) && w_free;
    w_ld      = w_free && (w_border || i_s_valid);
    w_ld_data = w_border ? w_pad_pix : i_s_data;
  end

  pad_out_reg #(
    .DW(DW)
  ) u_out_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ld    (w_ld),
    .i_data  (w_ld_data),
    .i_eol   (w_col_last),
    .i_eof   (w_col_last && w_row_last),
    .i_ready (i_m_ready),
    .o_valid (o_m_valid),
    .o_data  (o_m_data),
    .o_eol   (o_m_eol),
    .o_eof   (o_m_eof),
    .o_free  (w_free)
  );

  // Frame-done pulse follows the transfer of the last padded beat; err latches any bad row end.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= o_m_valid && i_m_ready && o_m_eof;
      if (i_s_valid && o_s_ready && (i_s_eol != w_img_col_last))
        r_err <= 1'b1;
    end
  end

  assign o_frame_done = r_frame_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_conv_pad_stream.sv
// Bench for conv_pad_stream: a padded 4x2 image (PAD=1) and an unpadded 3x1 image (PAD=0).
module tb_conv_pad_stream;

  localparam int DW   = 24;
  localparam int A_W  = 4;
  localparam int A_H  = 2;
  localparam int A_P  = 1;
  localparam int A_OW = A_W + 2 * A_P;
  localparam int A_OH = A_H + 2 * A_P;
  localparam int A_TOT = A_OW * A_OH;
  localparam logic [7:0] PADV = 8'd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: padded configuration
  logic          a_reset, a_s_valid, a_s_ready, a_s_eol;
  logic [DW-1:0] a_s_data, a_m_data;
  logic          a_m_valid, a_m_ready, a_m_eol, a_m_eof, a_frame_done, a_err;

  // DUT B: no border
  logic          b_reset, b_s_valid, b_s_ready, b_s_eol;
  logic [DW-1:0] b_s_data, b_m_data;
  logic          b_m_valid, b_m_ready, b_m_eol, b_m_eof, b_frame_done, b_err;

  int errors = 0;
  int checks = 0;

  // Reference-model state for DUT A
  int            a_pos    = 0;
  int            a_in_cnt = 0;
  bit            a_exp_err = 1'b0;
  logic [DW-1:0] a_sent[$];

  conv_pad_stream #(.CH(3), .PIX_W(8), .IMG_W(A_W), .IMG_H(A_H), .PAD(A_P), .PAD_VAL(PADV)) u_dut_a (
    .i_clk(clk), .i_reset(a_reset), .i_s_valid(a_s_valid), .o_s_ready(a_s_ready),
    .i_s_data(a_s_data), .i_s_eol(a_s_eol), .o_m_valid(a_m_valid), .i_m_ready(a_m_ready),
    .o_m_data(a_m_data), .o_m_eol(a_m_eol), .o_m_eof(a_m_eof),
    .o_frame_done(a_frame_done), .o_err(a_err)
  );

  conv_pad_stream #(.CH(3), .PIX_W(8), .IMG_W(3), .IMG_H(1), .PAD(0), .PAD_VAL(8'd0)) u_dut_b (
    .i_clk(clk), .i_reset(b_reset), .i_s_valid(b_s_valid), .o_s_ready(b_s_ready),
    .i_s_data(b_s_data), .i_s_eol(b_s_eol), .o_m_valid(b_m_valid), .i_m_ready(b_m_ready),
    .o_m_data(b_m_data), .o_m_eol(b_m_eol), .o_m_eof(b_m_eof),
    .o_frame_done(b_frame_done), .o_err(b_err)
  );

  // Is padded-raster position p inside the image area?
  function automatic bit a_is_body(input int p);
    int r, c;
    r = p / A_OW;
    c = p % A_OW;
    return (r >= A_P) && (r < A_P + A_H) && (c >= A_P) && (c < A_P + A_W);
  endfunction

  // Drive DUT A until nbeats output beats transfer, checking every beat against the raster model.
  // rpct < 0 selects the fixed m_ready pattern 1,0,0,1.
  task automatic stream_a(input int nbeats, input int vpct, input int rpct,
                          input int bad_idx, input bit inc);
    int done, cyc, r, c;
    bit fd_pend, hold_prev, exp_eol, exp_eof, exp_rdy;
    logic [DW-1:0] prev_data, exp_data;
    logic prev_eol, prev_eof;
    done = 0; cyc = 0; fd_pend = 0; hold_prev = 0;
    prev_data = '0; prev_eol = 0; prev_eof = 0;
    while (done < nbeats) begin
      a_s_valid = ($urandom_range(0, 99) < vpct);
      if (rpct < 0) a_m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else          a_m_ready = ($urandom_range(0, 99) < rpct);
      a_s_data = inc ? {3{8'(a_in_cnt + 1)}} : DW'($urandom);
      a_s_eol  = ((a_in_cnt % A_W) == A_W - 1) ^ (a_in_cnt == bad_idx);
      @(negedge clk);
      exp_rdy = a_is_body((a_pos + (a_m_valid ? 1 : 0)) % A_TOT) && (!a_m_valid || a_m_ready);
      checks++;
      if (a_s_ready !== exp_rdy) begin
        errors++;
        $display("FAIL s_ready pos=%0d got=%b exp=%b", a_pos, a_s_ready, exp_rdy);
      end
      checks++;
      if (a_err !== a_exp_err) begin
        errors++;
        $display("FAIL err pos=%0d got=%b exp=%b", a_pos, a_err, a_exp_err);
      end
      checks++;
      if (a_frame_done !== fd_pend) begin
        errors++;
        $display("FAIL frame_done pos=%0d got=%b exp=%b", a_pos, a_frame_done, fd_pend);
      end
      fd_pend = 0;
      if (hold_prev) begin
        checks++;
        if (a_m_valid !== 1'b1 || a_m_data !== prev_data || a_m_eol !== prev_eol || a_m_eof !== prev_eof) begin
          errors++;
          $display("FAIL hold pos=%0d got v=%b d=%h exp v=1 d=%h", a_pos, a_m_valid, a_m_data, prev_data);
        end
      end
      hold_prev = (a_m_valid === 1'b1) && !a_m_ready;
      prev_data = a_m_data; prev_eol = a_m_eol; prev_eof = a_m_eof;
      if (a_m_valid === 1'b1 && a_m_ready) begin
        r = a_pos / A_OW;
        c = a_pos % A_OW;
        if (a_is_body(a_pos)) begin
          if (a_sent.size() == 0) begin
            checks++; errors++;
            $display("FAIL underflow pos=%0d got=%h exp=<no input sent>", a_pos, a_m_data);
            exp_data = a_m_data;
          end else begin
            exp_data = a_sent.pop_front();
          end
        end else begin
          exp_data = {3{PADV}};
        end
        exp_eol = (c == A_OW - 1);
        exp_eof = exp_eol && (r == A_OH - 1);
        checks++;
        if (a_m_data !== exp_data) begin
          errors++;
          $display("FAIL data pos=%0d got=%h exp=%h", a_pos, a_m_data, exp_data);
        end
        checks++;
        if ({a_m_eol, a_m_eof} !== {exp_eol, exp_eof}) begin
          errors++;
          $display("FAIL markers pos=%0d got eol=%b eof=%b exp eol=%b eof=%b",
                   a_pos, a_m_eol, a_m_eof, exp_eol, exp_eof);
        end
        $display("beat pos=%0d data=%h eol=%b eof=%b", a_pos, a_m_data, a_m_eol, a_m_eof);
        fd_pend = exp_eof;
        a_pos = (a_pos + 1) % A_TOT;
        done++;
      end
      if (a_s_valid && a_s_ready === 1'b1) begin
        a_sent.push_back(a_s_data);
        if (a_in_cnt == bad_idx) a_exp_err = 1'b1;
        a_in_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > nbeats * 30 + 100) begin
        checks++; errors++;
        $display("FAIL timeout beats got=%0d exp=%0d", done, nbeats);
        break;
      end
    end
    // Idle tail cycle so a pending frame_done pulse is also observed.
    a_s_valid = 1'b0;
    a_m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (a_frame_done !== fd_pend) begin
      errors++;
      $display("FAIL frame_done_tail got=%b exp=%b", a_frame_done, fd_pend);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    a_reset = 1; b_reset = 1;
    a_s_valid = 0; a_m_ready = 0; a_s_data = '0; a_s_eol = 0;
    b_s_valid = 0; b_m_ready = 0; b_s_data = '0; b_s_eol = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_m_valid, a_m_eol, a_m_eof, a_frame_done, a_err, a_s_ready} !== 6'b0 || a_m_data !== '0) begin
      errors++;
      $display("FAIL reset_a got v=%b d=%h rdy=%b exp all 0", a_m_valid, a_m_data, a_s_ready);
    end
    checks++;
    if (b_s_ready !== 1'b1 || b_m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got rdy=%b v=%b exp rdy=1 v=0", b_s_ready, b_m_valid);
    end
    @(posedge clk); #1;
    a_reset = 0; b_reset = 0;
    @(posedge clk); #1;
    checks++;
    if (a_m_valid !== 1'b1 || a_m_data !== '0) begin
      errors++;
      $display("FAIL first_border got v=%b d=%h exp v=1 d=0", a_m_valid, a_m_data);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    stream_a(A_TOT, 100, 100, -1, 1'b1);
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    stream_a(2 * A_TOT, 100, -1, -1, 1'b1);
    $display("test_backpressure done");
  endtask

  task automatic test_stall();
    int k;
    k = 0;
    while (!a_is_body((a_pos + k) % A_TOT)) k++;
    stream_a(k, 0, 100, -1, 1'b0);
    a_s_valid = 0;
    a_m_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1) begin
        errors++;
        $display("FAIL stall cyc=%0d got v=%b rdy=%b exp v=0 rdy=1", i, a_m_valid, a_s_ready);
      end
      @(posedge clk); #1;
    end
    stream_a(A_TOT - k, 60, 70, -1, 1'b0);
    $display("test_stall done");
  endtask

  task automatic test_random();
    stream_a(3 * A_TOT, 70, 70, -1, 1'b0);
    $display("test_random done");
  endtask

  task automatic test_err();
    int bad;
    bad = a_in_cnt;
    while (bad % A_W != 1) bad++;
    stream_a(A_TOT, 80, 80, bad, 1'b0);
    checks++;
    if (a_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b exp=1", a_err);
    end
    $display("test_err done");
  endtask

  task automatic test_midreset();
    stream_a(2 * A_OW + 2, 100, 100, -1, 1'b0);
    a_reset = 1;
    #1;
    checks++;
    if ({a_m_valid, a_m_eol, a_m_eof, a_frame_done, a_err, a_s_ready} !== 6'b0 || a_m_data !== '0) begin
      errors++;
      $display("FAIL midreset got v=%b d=%h err=%b rdy=%b exp all 0", a_m_valid, a_m_data, a_err, a_s_ready);
    end
    @(posedge clk); #1;
    a_reset = 0;
    a_pos = 0; a_in_cnt = 0; a_exp_err = 0;
    a_sent.delete();
    @(posedge clk); #1;
    checks++;
    if (a_m_valid !== 1'b1 || a_m_data !== '0) begin
      errors++;
      $display("FAIL restart got v=%b d=%h exp v=1 d=0", a_m_valid, a_m_data);
    end
    stream_a(A_TOT, 100, 100, -1, 1'b1);
    $display("test_midreset done");
  endtask

  task automatic test_pad0();
    logic [DW-1:0] exp_d;
    bit exp_v, exp_fd, exp_mk;
    for (int i = 0; i < 8; i++) begin
      b_s_valid = (i < 6);
      b_m_ready = 1;
      b_s_data  = (i < 6) ? {3{8'(7 + i % 3)}} : '0;
      b_s_eol   = (i < 6) && (i % 3 == 2);
      @(negedge clk);
      exp_v  = (i >= 1) && (i <= 6);
      exp_fd = (i == 4) || (i == 7);
      checks++;
      if (b_s_ready !== 1'b1) begin
        errors++;
        $display("FAIL pad0_ready cyc=%0d got=%b exp=1", i, b_s_ready);
      end
      checks++;
      if (b_m_valid !== exp_v) begin
        errors++;
        $display("FAIL pad0_valid cyc=%0d got=%b exp=%b", i, b_m_valid, exp_v);
      end
      checks++;
      if (b_frame_done !== exp_fd) begin
        errors++;
        $display("FAIL pad0_frame_done cyc=%0d got=%b exp=%b", i, b_frame_done, exp_fd);
      end
      if (exp_v) begin
        exp_d  = {3{8'(7 + (i - 1) % 3)}};
        exp_mk = ((i - 1) % 3 == 2);
        checks++;
        if (b_m_data !== exp_d || b_m_eol !== exp_mk || b_m_eof !== exp_mk) begin
          errors++;
          $display("FAIL pad0_beat cyc=%0d got d=%h eol=%b eof=%b exp d=%h eol=%b eof=%b",
                   i, b_m_data, b_m_eol, b_m_eof, exp_d, exp_mk, exp_mk);
        end
        $display("pad0 beat cyc=%0d data=%h eol=%b eof=%b", i, b_m_data, b_m_eol, b_m_eof);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (b_err !== 1'b0) begin
      errors++;
      $display("FAIL pad0_err got=%b exp=0", b_err);
    end
    $display("test_pad0 done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_random();
    test_err();
    test_midreset();
    test_pad0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog got=hung exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_pad_stream.md
# conv_pad_stream

Parametrised zero-padding stage for the convolution front end. It accepts an unpadded image as a raster stream of multi-channel pixels over a valid/ready handshake and emits the padded raster. The output is framed by PAD border rows and columns on every side, with end-of-row and end-of-frame markers. It sits between the input pixel fetch and the convolution window buffer, and replaces fixed-width, fixed-size row padding with a generic size, channel count and border.

## Interface
- CH, 3: channels per pixel, carried in parallel.
- PIX_W, 8: bits per channel sample.
- IMG_W, 416: unpadded image width in pixels, ≥1.
- IMG_H, 416: unpadded image height in rows, ≥1.
- PAD, 1: border width in pixels/rows, 0..7.
- PAD_VAL, 0: PIX_W-bit value written into border samples.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_data  in  CH*PIX_W  input pixel; channel c is bits [c*PIX_W +: PIX_W].
- s_eol  in  1  producer's end-of-row flag; checked, never trusted.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts.
- m_data  out  CH*PIX_W  padded pixel.
- m_eol  out  1  last pixel of a padded row.
- m_eof  out  1  last pixel of the padded frame.
- frame_done  out  1  one-cycle pulse when the m_eof beat transfers.
- err  out  1  sticky; s_eol mismatch seen; cleared only by reset.

## Operation
- Padded frame geometry:
  - OW = IMG_W+2*PAD columns by OH = IMG_H+2*PAD rows.
  - Exactly OW*OH output beats per frame, in raster order.
- Counters: col (0..OW-1) and row (0..OH-1), each sized $clog2 of its limit.
  - Both advance only on an output-register load.
- Beat classification:
  - Border beat: row<PAD, row≥PAD+IMG_H, col<PAD, or col≥PAD+IMG_W.
  - Body beat: every other beat.
- FSM states:
  - TOP: row<PAD.
  - LEFT: col<PAD.
  - BODY: image columns.
  - RIGHT: col≥PAD+IMG_W.
  - BOT: row≥PAD+IMG_H.
- FSM transitions:
  - Follow the counters.
  - With PAD=0, TOP/LEFT/RIGHT/BOT are never entered; the reset state is BODY.
  - After the m_eof load, the FSM wraps to row=0, col=0 and the next frame starts with no idle cycle.
- Load sources:
  - Border beats are generated internally (all channels = PAD_VAL) and consume no input.
  - Body beats consume exactly one input transfer.
- Handshake:
  - Load enable ld = (!m_valid || m_ready) && (border || s_valid).
  - s_ready = (state==BODY) && (!m_valid || m_ready). Combinational, with no dependency on s_valid.
  - Once m_valid is high, m_data, m_eol and m_eof hold stable until m_ready.
- Markers:
  - m_eol is set on the load where col==OW-1.
  - m_eof is set on the load where col==OW-1 && row==OH-1.
- Error check, on each body-beat input transfer:
  - err sets if s_eol != (col==PAD+IMG_W-1).
  - Data flow is unaffected.
- Simultaneous unload and load: in the same cycle m_ready drains the current beat and the next beat is loaded. Full throughput is 1 beat/cycle.

## Timing
- Reset values:
  - s_ready=0 if PAD>0, else 1 while !m_valid.
  - m_valid=0; m_data=0; m_eol=0; m_eof=0; frame_done=0; err=0.
  - row=col=0; state=TOP (or BODY if PAD=0).
- Latency:
  - First output m_valid is 1 cycle after reset release (border), or 1 cycle after the first input transfer (PAD=0).
  - Body data appears at m_data 1 cycle after its input transfer.
- Steady state with m_ready=1 and s_valid=1: one output every cycle; s_ready is low during border beats.
- Backpressure: with m_ready=0, the register holds. s_ready is 0 and no counter moves.
- frame_done: high the cycle after the m_eof transfer.
- Reset mid-frame: takes effect asynchronously. Any partial frame is discarded; no flush is emitted.

## Structure
- Shared package conv_pkg holds:
  - the pad_state_t enum (TOP, LEFT, BODY, RIGHT, BOT);
  - the PIX_W default;
  - the pixel-slice helper constants.
- Natural sub-module: pad_out_reg.
  - One-entry valid/ready pipeline register carrying {m_data, m_eol, m_eof}.
  - Accepts ld and exposes its "free" term (!m_valid || m_ready).
- The top level holds the counters, FSM, source mux and err logic.

## Test plan
- IMG_W=4, IMG_H=2, PAD=1, CH=3, m_ready=1, s_valid=1, inputs 1..8 with correct s_eol:
  - Expect 24 beats: 7 zeros, then 1,2,3,4.
  - Then 0,0 ahead of 5,6,7,8.
  - Then 0 and 6 zeros.
  - m_eol on beats 6,12,18,24; m_eof and frame_done once, on beat 24.
- Same config with m_ready toggling 1,0,0,1 repeatedly: identical beat sequence; m_data is stable while m_valid && !m_ready; no beat is lost or duplicated.
- s_valid=0 during BODY: output stalls after the border; m_valid drops; the counters hold until input resumes.
- PAD=0, IMG_W=3, IMG_H=1: input 7,8,9 gives output 7,8,9 with m_eol and m_eof on 9 and 1-cycle latency. Two back-to-back frames run with no gap.
- s_eol asserted on the 2nd body pixel of a row: err goes 1 and stays 1. Output data matches the no-error run.
- reset asserted mid-row 2: all outputs are 0 immediately. After release, the output restarts at row 0, col 0 with 7 border zeros (PAD=1, IMG_W=4).
